// File: rtl/score_streamer.sv
`default_nettype none
// ============================================================================
// Module   : score_streamer
// Purpose  : Captures NEURON_NB signed scores in one cycle, then streams them
//            out one per valid/ready transfer with index, last flag and done.
//            Optional macro SCORE_RELU_EN clamps negative scores to 0 at capture.
// Revision : 1.0  initial release
// ============================================================================
module score_streamer #(
    parameter int NEURON_NB = 10,
    parameter int WIDTH     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic signed [2*WIDTH-1:0]   in_data [0:NEURON_NB-1],
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [2*WIDTH-1:0]   out_data,
    output logic [WIDTH-1:0]            out_index,
    output logic                        out_last,
    output logic                        done
);

    localparam int               c_DW       = 2 * WIDTH;
    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_STREAM   = 2'd1;
    localparam logic [1:0]       c_DONE     = 2'd2;
    localparam logic [WIDTH-1:0] c_LAST_IDX = WIDTH'(NEURON_NB - 1);

    logic [1:0]              state_q, state_d;
    logic [WIDTH-1:0]        index_q, index_d;
    logic signed [c_DW-1:0]  score_q [0:NEURON_NB-1];
    logic signed [c_DW-1:0]  score_d [0:NEURON_NB-1];
    logic                    xfer;

    assign xfer = (state_q == c_STREAM) && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (load) state_d = c_STREAM;
            c_STREAM: if (xfer && (index_q == c_LAST_IDX)) state_d = c_DONE;
            c_DONE:   state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
    end

    // Capture buffer and element index
    always_ff @(posedge clk) begin
        if (!reset) begin
            index_q <= '0;
            for (int i = 0; i < NEURON_NB; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            index_q <= index_d;
            for (int i = 0; i < NEURON_NB; i++) begin
                score_q[i] <= score_d[i];
            end
        end
    end

    always_comb begin
        index_d = index_q;
        for (int i = 0; i < NEURON_NB; i++) begin
            score_d[i] = score_q[i];
        end
        if ((state_q == c_IDLE) && load) begin
            index_d = '0;
            for (int i = 0; i < NEURON_NB; i++) begin
`ifdef SCORE_RELU_EN
                score_d[i] = in_data[i][c_DW-1] ? '0 : in_data[i];
`else
                score_d[i] = in_data[i];
`endif
            end
        end else if (xfer) begin
            // Return to 0 after the last element so IDLE shows index 0
            index_d = (index_q == c_LAST_IDX) ? '0 : index_q + WIDTH'(1);
        end
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == c_STREAM);
        busy      = (state_q != c_IDLE);
        done      = (state_q == c_DONE);
        out_index = index_q;
        out_last  = out_valid && (index_q == c_LAST_IDX);
        out_data  = '0;
        for (int i = 0; i < NEURON_NB; i++) begin
            if (out_valid && (index_q == WIDTH'(i))) begin
                out_data = score_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_streamer
// Purpose  : Scoreboard bench for score_streamer; stimulus queues expected
//            elements, a negedge monitor pops and compares on each transfer.
// Revision : 1.0  initial release
// ============================================================================
module tb_score_streamer;

    localparam int N = 10;
    localparam int W = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               load = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [15:0] in_data [0:N-1];
    logic               busy;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic [W-1:0]       out_index;
    logic               out_last;
    logic               done;

    score_streamer #(.NEURON_NB(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  idx;
        logic        last;
    } elem_t;

    elem_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          ready_mode = 0;
    int          rcnt = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_data = '0;
    logic [7:0]  prev_idx = '0;

    logic signed [15:0] frame_a [0:N-1];
    logic signed [15:0] frame_b [0:N-1];
    logic signed [15:0] frame_c [0:N-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] expect_score(input logic [15:0] v);
`ifdef SCORE_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic push_frame(input int sel);
        logic [15:0] v;
        for (int i = 0; i < N; i++) begin
            v = (sel == 0) ? frame_a[i] : frame_b[i];
            exp_q.push_back('{expect_score(v), 8'(i), (i == N - 1)});
        end
    endtask

    task automatic start_frame(input int sel);
        @(posedge clk);
        #1;
        in_data = (sel == 0) ? frame_a : frame_b;
        load = 1'b1;
        push_frame(sel);
        @(posedge clk);
        #1;
        load = 1'b0;
        in_data = frame_c;
    endtask

    task automatic wait_done(input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < bound);
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, required a done pulse", cycles);
        end
    endtask

    task automatic wait_index(input int k);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(out_valid && out_index == 8'(k)) && cnt < 50);
        if (!(out_valid && out_index == 8'(k))) begin
            total++;
            bad++;
            $display("FAIL index_timeout: got index %0d, required %0d", out_index, k);
        end
    endtask

    // Ready pattern: mode 0 always ready, mode 1 repeats 1,0,0
    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
        rcnt++;
    end

    always @(negedge clk) begin
        elem_t e;
        if (reset) begin
            if (done) done_cnt++;
            if (stall_prev) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_data",  {16'b0, out_data}, {16'b0, prev_data});
                chk("hold_index", {24'b0, out_index}, {24'b0, prev_idx});
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_index;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_elem: got index %0d data %0h, required no transfer", out_index, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("elem_data",  {16'b0, out_data}, {16'b0, e.data});
                    chk("elem_index", {24'b0, out_index}, {24'b0, e.idx});
                    chk("elem_last",  {31'b0, out_last}, {31'b0, e.last});
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dc;
        frame_a = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, -16'sd1, 16'sd30, 16'sd2, 16'sd2, 16'sd9};
        frame_b = '{16'sd100, -16'sd200, 16'sd3, -16'sd4, 16'sd50, 16'sd6, -16'sd7, 16'sd8, 16'sd9, -16'sd10};
        frame_c = '{16'sh7777, 16'sh8888, 16'sh1234, 16'sh4321, 16'sh5555,
                    16'shAAAA, 16'sh0F0F, 16'shF0F0, 16'sh3C3C, 16'shC3C3};
        in_data = frame_a;

        // Reset, then idle with no load
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle_valid", {31'b0, out_valid}, 32'd0);
            chk("idle_busy",  {31'b0, busy}, 32'd0);
            chk("idle_done",  {31'b0, done}, 32'd0);
            chk("idle_index", {24'b0, out_index}, 32'd0);
            chk("idle_data",  {16'b0, out_data}, 32'd0);
        end

        // Full-rate frame: first valid 1 cycle after load, done after 10 transfers
        ready_mode = 0;
        start_frame(0);
        @(negedge clk);
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        chk("first_index", {24'b0, out_index}, 32'd0);
        chk("first_busy",  {31'b0, busy}, 32'd1);
        wait_done(40, cyc);
        chk("done_latency", cyc, N);
        chk("done_busy", {31'b0, busy}, 32'd1);
        chk("done_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("busy_fall", {31'b0, busy}, 32'd0);
        chk("frame1_drained", exp_q.size(), 32'd0);

        // Back-pressure frame
        ready_mode = 1;
        start_frame(0);
        wait_done(100, cyc);
        ready_mode = 0;
        @(negedge clk);
        chk("frame2_drained", exp_q.size(), 32'd0);

        // Load during stream is ignored, then a new frame from IDLE
        start_frame(0);
        wait_index(4);
        @(posedge clk);
        #1;
        in_data = frame_b;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        wait_done(40, cyc);
        @(negedge clk);
        chk("frame3_drained", exp_q.size(), 32'd0);
        start_frame(1);
        @(negedge clk);
        chk("newframe_index", {24'b0, out_index}, 32'd0);
        wait_done(40, cyc);
        @(negedge clk);
        chk("frame4_drained", exp_q.size(), 32'd0);

        // Reset mid-stream abandons the frame with no done pulse
        start_frame(0);
        wait_index(6);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        dc = done_cnt;
        @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_index", {24'b0, out_index}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (14) @(negedge clk);
        chk("no_done_after_reset", done_cnt, dc);
        start_frame(1);
        wait_done(40, cyc);
        @(negedge clk);
        chk("frame5_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
